scaler_h_ctrl: RTL and testbench

- Frame-level sequencer and configuration shadow for the horizontal scaler.
- Sits between the video source and scaler_h. It gates the input stream so the scaler only ever starts on a frame boundary.
- Applies host scale-step updates only during vertical blanking.
- Measures input line width, frame height and scaler output line width for status and error reporting.

---
 rtl/scaler_pkg.sv | 19 +
 rtl/scaler_line_meter.sv | 37 +++
 rtl/scaler_h_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_scaler_h_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scaler_pkg.sv
// rtl/scaler_pkg.sv - shared types, step constants and helpers for the horizontal scaler control
package scaler_pkg;

    localparam int unsigned STEP_ONE = 4096;
    localparam int unsigned STEP_MIN = 512;

    typedef logic [15:0] step_t;

    typedef enum logic [1:0] {
        S_SYNC,
        S_VBLANK,
        S_ACTIVE
    } state_t;

    function automatic step_t clamp_step(input step_t req, input step_t lo);
        return (req < lo) ? lo : req;
    endfunction

endpackage

// File: rtl/scaler_line_meter.sv
// rtl/scaler_line_meter.sv - saturating per-line counter with rising-edge detect on the blank input
module scaler_line_meter #(
    parameter int CNT_WIDTH = 13
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc,
    input  logic                 clr,
    input  logic                 blank,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 rise,
    output logic                 sat
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic blank_q;

    assign rise = blank & ~blank_q;
    assign sat  = inc & ~clr & (count == CNT_MAX);

    // blank_q resets high so leaving reset during blanking never looks like a line end
    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= '0;
            blank_q <= 1'b1;
        end else begin
            blank_q <= blank;
            if (clr) begin
                count <= '0;
            end else if (inc && (count != CNT_MAX)) begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/scaler_h_ctrl.sv
// rtl/scaler_h_ctrl.sv - frame sequencer, step shadow and line/frame measurement for scaler_h
module scaler_h_ctrl
    import scaler_pkg::*;
#(
    parameter int          DATA_WIDTH = 8,
    parameter int unsigned STEP_ONE   = scaler_pkg::STEP_ONE,
    parameter int unsigned STEP_MIN   = scaler_pkg::STEP_MIN,
    parameter int          CNT_WIDTH  = 13
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [15:0]           cfg_step_i,
    input  logic                  cfg_bypass_i,
    input  logic                  cfg_wr_i,
    input  logic                  err_clr_i,
    input  logic [DATA_WIDTH-1:0] di_i,
    input  logic                  de_i,
    input  logic                  hs_i,
    input  logic                  vs_i,
    output logic [DATA_WIDTH-1:0] sc_di_o,
    output logic                  sc_de_o,
    output logic                  sc_hs_o,
    output logic                  sc_vs_o,
    output logic [15:0]           step_cord_o,
    input  logic                  sc_de_i,
    input  logic                  sc_hs_i,
    output logic                  cfg_pending_o,
    output logic [CNT_WIDTH-1:0]  line_width_o,
    output logic [CNT_WIDTH-1:0]  frame_height_o,
    output logic [CNT_WIDTH-1:0]  out_width_o,
    output logic                  frame_done_o,
    output logic                  err_width_o,
    output logic                  err_ovf_o
);

    localparam step_t                STEP_ONE_V = step_t'(STEP_ONE);
    localparam step_t                STEP_MIN_V = step_t'(STEP_MIN);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;

    state_t state;

    step_t shadow_step;
    logic  shadow_bypass;
    logic  apply;

    logic [CNT_WIDTH-1:0] pix_cnt;
    logic [CNT_WIDTH-1:0] opix_cnt;
    logic [CNT_WIDTH-1:0] line_cnt;
    logic [CNT_WIDTH-1:0] ref_width;
    logic [CNT_WIDTH-1:0] last_owidth;
    logic [CNT_WIDTH-1:0] line_cnt_nxt;
    logic [CNT_WIDTH-1:0] ref_nxt;

    logic pix_inc;
    logic hs_rise;
    logic pix_sat;
    logic ohs_rise;
    logic opix_sat;
    logic frame_end;
    logic line_close;
    logic line_sat;
    logic width_bad;
    logic ovf_evt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_SYNC;
        end else begin
            case (state)
                S_SYNC:   if (vs_i)  state <= S_VBLANK;
                S_VBLANK: if (!vs_i) state <= S_ACTIVE;
                S_ACTIVE: if (vs_i)  state <= S_VBLANK;
                default:             state <= S_SYNC;
            endcase
        end
    end

    // The shadow is only transferred while the scaler is idle between frames
    assign apply = (state != S_ACTIVE) && cfg_pending_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            sc_di_o       <= '0;
            sc_de_o       <= 1'b0;
            sc_hs_o       <= 1'b1;
            sc_vs_o       <= 1'b1;
            step_cord_o   <= STEP_ONE_V;
            shadow_step   <= STEP_ONE_V;
            shadow_bypass <= 1'b0;
            cfg_pending_o <= 1'b0;
        end else begin
            sc_di_o <= di_i;
            sc_de_o <= de_i && (state == S_ACTIVE);
            sc_hs_o <= hs_i;
            sc_vs_o <= vs_i;

            if (apply) begin
                step_cord_o <= shadow_bypass ? STEP_ONE_V : shadow_step;
            end

            if (cfg_wr_i) begin
                shadow_step   <= clamp_step(cfg_step_i, STEP_MIN_V);
                shadow_bypass <= cfg_bypass_i;
                cfg_pending_o <= 1'b1;
            end else if (apply) begin
                cfg_pending_o <= 1'b0;
            end
        end
    end

    assign pix_inc = de_i && (state == S_ACTIVE);

    scaler_line_meter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_in_meter (
        .clk   (clk),
        .rst   (rst),
        .inc   (pix_inc),
        .clr   (line_close),
        .blank (hs_i),
        .count (pix_cnt),
        .rise  (hs_rise),
        .sat   (pix_sat)
    );

    scaler_line_meter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_out_meter (
        .clk   (clk),
        .rst   (rst),
        .inc   (sc_de_i),
        .clr   (sc_hs_i),
        .blank (sc_hs_i),
        .count (opix_cnt),
        .rise  (ohs_rise),
        .sat   (opix_sat)
    );

    assign frame_end = (state == S_ACTIVE) && vs_i;

    // A line still open when vblank starts is closed by the frame end itself
    assign line_close = (state == S_ACTIVE) && (pix_cnt != '0) && (hs_rise || vs_i);
    assign line_sat   = line_close && (line_cnt == CNT_MAX);
    assign width_bad  = line_close && (line_cnt != '0) && (pix_cnt != ref_width);
    assign ovf_evt    = pix_sat | opix_sat | line_sat;

    always_comb begin
        line_cnt_nxt = line_cnt;
        ref_nxt      = ref_width;
        if (line_close && !line_sat) begin
            line_cnt_nxt = line_cnt + 1'b1;
        end
        if (line_close && (line_cnt == '0)) begin
            ref_nxt = pix_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            line_cnt       <= '0;
            ref_width      <= '0;
            last_owidth    <= '0;
            line_width_o   <= '0;
            frame_height_o <= '0;
            out_width_o    <= '0;
            frame_done_o   <= 1'b0;
            err_width_o    <= 1'b0;
            err_ovf_o      <= 1'b0;
        end else begin
            if (ohs_rise && (opix_cnt != '0)) begin
                last_owidth <= opix_cnt;
            end

            frame_done_o <= frame_end;
            if (frame_end) begin
                line_width_o   <= ref_nxt;
                frame_height_o <= line_cnt_nxt;
                out_width_o    <= last_owidth;
                line_cnt       <= '0;
                ref_width      <= '0;
            end else begin
                line_cnt  <= line_cnt_nxt;
                ref_width <= ref_nxt;
            end

            // A set event in the same cycle as a clear keeps the flag raised
            err_width_o <= width_bad | (err_width_o & ~err_clr_i);
            err_ovf_o   <= ovf_evt   | (err_ovf_o   & ~err_clr_i);
        end
    end

endmodule

// File: tb/tb_scaler_h_ctrl.sv
// tb/tb_scaler_h_ctrl.sv - self-checking bench for scaler_h_ctrl
module tb_scaler_h_ctrl;
    import scaler_pkg::*;

    logic        clk;
    logic        rst;
    logic [15:0] cfg_step_i;
    logic        cfg_bypass_i;
    logic        cfg_wr_i;
    logic        err_clr_i;
    logic [7:0]  di_i;
    logic        de_i;
    logic        hs_i;
    logic        vs_i;
    logic [7:0]  sc_di_o;
    logic        sc_de_o;
    logic        sc_hs_o;
    logic        sc_vs_o;
    logic [15:0] step_cord_o;
    logic        sc_de_i;
    logic        sc_hs_i;
    logic        cfg_pending_o;
    logic [12:0] line_width_o;
    logic [12:0] frame_height_o;
    logic [12:0] out_width_o;
    logic        frame_done_o;
    logic        err_width_o;
    logic        err_ovf_o;

    scaler_h_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .cfg_step_i     (cfg_step_i),
        .cfg_bypass_i   (cfg_bypass_i),
        .cfg_wr_i       (cfg_wr_i),
        .err_clr_i      (err_clr_i),
        .di_i           (di_i),
        .de_i           (de_i),
        .hs_i           (hs_i),
        .vs_i           (vs_i),
        .sc_di_o        (sc_di_o),
        .sc_de_o        (sc_de_o),
        .sc_hs_o        (sc_hs_o),
        .sc_vs_o        (sc_vs_o),
        .step_cord_o    (step_cord_o),
        .sc_de_i        (sc_de_i),
        .sc_hs_i        (sc_hs_i),
        .cfg_pending_o  (cfg_pending_o),
        .line_width_o   (line_width_o),
        .frame_height_o (frame_height_o),
        .out_width_o    (out_width_o),
        .frame_done_o   (frame_done_o),
        .err_width_o    (err_width_o),
        .err_ovf_o      (err_ovf_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] di;
        logic       de;
        logic       hs;
        logic       vs;
    } vid_t;

    typedef struct {
        int w;
        int h;
        int ow;
    } frm_t;

    typedef struct {
        logic [15:0] step;
        logic        byp;
        logic [15:0] exp;
    } cfg_vec_t;

    vid_t vq[$];
    frm_t fq[$];

    int n_pass = 0;
    int n_total = 0;
    int done_cnt = 0;
    int de_out_cnt = 0;
    int exp_ow = 0;
    int de_before;
    bit loop_en = 0;
    bit phase = 0;

    state_t      m_state = S_SYNC;
    logic [15:0] m_step = 16'd4096;
    logic [15:0] m_shadow = 16'd4096;
    logic        m_byp = 1'b0;
    logic        m_pending = 1'b0;

    cfg_vec_t tbl[8];

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        vid_t e;
        frm_t f;
        bit   apply;
        if (loop_en) begin
            sc_hs_i = hs_i;
            sc_de_i = de_i && !phase;
        end else begin
            sc_hs_i = 1'b1;
            sc_de_i = 1'b0;
        end
        if (rst) begin
            e.di = 8'd0; e.de = 1'b0; e.hs = 1'b1; e.vs = 1'b1;
        end else begin
            e.di = di_i; e.de = de_i && (m_state == S_ACTIVE); e.hs = hs_i; e.vs = vs_i;
        end
        vq.push_back(e);
        if (rst) begin
            m_state = S_SYNC; m_step = 16'd4096; m_shadow = 16'd4096;
            m_byp = 1'b0; m_pending = 1'b0;
        end else begin
            apply = (m_state != S_ACTIVE) && m_pending;
            if (apply) m_step = m_byp ? 16'd4096 : m_shadow;
            if (cfg_wr_i) begin
                m_shadow  = (cfg_step_i < 16'd512) ? 16'd512 : cfg_step_i;
                m_byp     = cfg_bypass_i;
                m_pending = 1'b1;
            end else if (apply) begin
                m_pending = 1'b0;
            end
            case (m_state)
                S_SYNC:   if (vs_i)  m_state = S_VBLANK;
                S_VBLANK: if (!vs_i) m_state = S_ACTIVE;
                default:  if (vs_i)  m_state = S_VBLANK;
            endcase
        end
        if (loop_en) begin
            if (hs_i) phase = 1'b0;
            else if (de_i) phase = ~phase;
        end
        @(posedge clk);
        #1;
        e = vq.pop_front();
        check("sc_di_o", sc_di_o, e.di);
        check("sc_de_o", sc_de_o, e.de);
        check("sc_hs_o", sc_hs_o, e.hs);
        check("sc_vs_o", sc_vs_o, e.vs);
        check("step_cord_o", step_cord_o, m_step);
        check("cfg_pending_o", cfg_pending_o, m_pending);
        if (sc_de_o) de_out_cnt++;
        if (frame_done_o) begin
            done_cnt++;
            if (fq.size() == 0) begin
                check("unexpected_frame_done", 1, 0);
            end else begin
                f = fq.pop_front();
                check("line_width_o", line_width_o, f.w);
                check("frame_height_o", frame_height_o, f.h);
                check("out_width_o", out_width_o, f.ow);
            end
        end
    endtask

    // v0 is written on line 1 and v1 on line 3 when nonzero
    task automatic lines(input int w, input int h, input int short_idx, input int short_w,
                         input int v0, input int v1, input bit last_open);
        for (int l = 0; l < h; l++) begin
            int lw;
            lw = (l == short_idx) ? short_w : w;
            hs_i = 1'b0;
            vs_i = 1'b0;
            for (int p = 0; p < lw; p++) begin
                de_i = 1'b0;
                tick();
                de_i = 1'b1;
                di_i = 8'($urandom);
                if (p == 0 && ((l == 1 && v0 != 0) || (l == 3 && v1 != 0))) begin
                    cfg_wr_i     = 1'b1;
                    cfg_step_i   = 16'((l == 1) ? v0 : v1);
                    cfg_bypass_i = 1'b0;
                end
                tick();
                cfg_wr_i = 1'b0;
            end
            de_i = 1'b0;
            if (!(last_open && l == h - 1)) begin
                hs_i = 1'b1;
                repeat (4) tick();
            end
        end
    endtask

    task automatic vblank(input int n, input int ew, input int eh);
        frm_t f;
        if (m_state == S_ACTIVE) begin
            f.w = ew; f.h = eh; f.ow = exp_ow;
            fq.push_back(f);
        end
        hs_i = 1'b1;
        vs_i = 1'b1;
        de_i = 1'b0;
        repeat (n) tick();
    endtask

    task automatic write_cfg(input logic [15:0] step, input logic byp);
        cfg_wr_i     = 1'b1;
        cfg_step_i   = step;
        cfg_bypass_i = byp;
        tick();
        cfg_wr_i = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0] = '{16'd2048,  1'b0, 16'd2048};
        tbl[1] = '{16'd100,   1'b0, 16'd512};
        tbl[2] = '{16'd511,   1'b0, 16'd512};
        tbl[3] = '{16'd512,   1'b0, 16'd512};
        tbl[4] = '{16'd2048,  1'b1, 16'd4096};
        tbl[5] = '{16'd65535, 1'b0, 16'd65535};
        tbl[6] = '{16'd8192,  1'b0, 16'd8192};
        tbl[7] = '{16'd0,     1'b1, 16'd4096};

        rst = 1'b1; cfg_step_i = 16'd0; cfg_bypass_i = 1'b0; cfg_wr_i = 1'b0;
        err_clr_i = 1'b0; di_i = 8'd0; de_i = 1'b0; hs_i = 1'b0; vs_i = 1'b0;
        sc_de_i = 1'b0; sc_hs_i = 1'b1;
        repeat (3) tick();
        check("rst_sc_hs_o", sc_hs_o, 1);
        check("rst_sc_vs_o", sc_vs_o, 1);
        check("rst_step_cord_o", step_cord_o, 4096);
        check("rst_line_width_o", line_width_o, 0);
        check("rst_frame_height_o", frame_height_o, 0);
        check("rst_out_width_o", out_width_o, 0);
        check("rst_frame_done_o", frame_done_o, 0);
        check("rst_err_width_o", err_width_o, 0);
        check("rst_err_ovf_o", err_ovf_o, 0);

        // Release inside a frame: the partial frame must be swallowed
        rst = 1'b0;
        lines(10, 3, -1, 0, 0, 0, 1'b0);
        check("partial_frame_de_blocked", de_out_cnt, 0);
        vblank(6, 0, 0);
        check("partial_frame_no_done", done_cnt, 0);

        lines(25, 25, -1, 0, 0, 0, 1'b0);
        vblank(6, 25, 25);
        check("frame25_done_count", done_cnt, 1);
        check("frame25_width", line_width_o, 25);
        check("frame25_height", frame_height_o, 25);
        check("frame25_err_width", err_width_o, 0);

        for (int i = 0; i < 8; i++) begin
            write_cfg(tbl[i].step, tbl[i].byp);
            check("tbl_pending", cfg_pending_o, 1);
            tick();
            check("tbl_step", step_cord_o, tbl[i].exp);
            check("tbl_pending_clear", cfg_pending_o, 0);
        end

        // Write colliding with an apply stays pending for one more cycle
        write_cfg(16'd1024, 1'b0);
        write_cfg(16'd3000, 1'b0);
        check("collide_step_first", step_cord_o, 1024);
        check("collide_pending", cfg_pending_o, 1);
        tick();
        check("collide_step_second", step_cord_o, 3000);
        write_cfg(16'd0, 1'b1);
        tick();
        check("bypass_restore", step_cord_o, 4096);

        lines(8, 4, -1, 0, 6000, 2048, 1'b0);
        check("active_cfg_pending", cfg_pending_o, 1);
        check("active_cfg_hold", step_cord_o, 4096);
        vblank(1, 8, 4);
        check("vs_rise_step_hold", step_cord_o, 4096);
        vblank(1, 0, 0);
        check("vblank_step_applied", step_cord_o, 2048);
        check("vblank_pending_clear", cfg_pending_o, 0);
        vblank(4, 0, 0);

        write_cfg(16'd8192, 1'b0);
        tick();
        check("loop_step", step_cord_o, 8192);
        loop_en = 1'b1;
        lines(24, 6, -1, 0, 0, 0, 1'b0);
        exp_ow = 12;
        vblank(6, 24, 6);
        loop_en = 1'b0;
        check("loop_out_width", out_width_o, 12);
        check("loop_line_width", line_width_o, 24);

        check("pre_short_err_width", err_width_o, 0);
        lines(24, 5, 2, 20, 0, 0, 1'b0);
        vblank(6, 24, 5);
        check("short_err_width", err_width_o, 1);
        lines(24, 3, -1, 0, 0, 0, 1'b0);
        vblank(6, 24, 3);
        check("sticky_err_width", err_width_o, 1);
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;
        check("cleared_err_width", err_width_o, 0);

        lines(10, 3, -1, 0, 0, 0, 1'b1);
        vblank(6, 10, 3);
        check("open_line_height", frame_height_o, 3);

        // Reset in the middle of an active line
        lines(10, 2, -1, 0, 0, 0, 1'b1);
        rst = 1'b1;
        de_i = 1'b1;
        repeat (2) tick();
        de_i = 1'b0;
        exp_ow = 0;
        check("midrst_step", step_cord_o, 4096);
        check("midrst_width", line_width_o, 0);
        check("midrst_out_width", out_width_o, 0);
        rst = 1'b0;
        de_before = de_out_cnt;
        lines(10, 2, -1, 0, 0, 0, 1'b0);
        check("midrst_blocked", de_out_cnt - de_before, 0);
        vblank(6, 0, 0);
        de_before = done_cnt;
        lines(10, 2, -1, 0, 0, 0, 1'b0);
        vblank(6, 10, 2);
        check("midrst_recovered_done", done_cnt - de_before, 1);

        check("frame_queue_drained", fq.size(), 0);
        check("err_ovf_never", err_ovf_o, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
